// File: rtl/testbasic12_feeder.sv
// Order-preserving circular buffer between a CompoundType producer and TestBasic12's b_in port.
// Optional same-cycle pass-through when empty: define TESTBASIC12_FEEDER_BYPASS_EN.

package testbasic12_types;
  typedef enum logic {
    MODE_READ  = 1'b0,
    MODE_WRITE = 1'b1
  } mode_t;

  typedef struct packed {
    mode_t              mode;
    logic signed [31:0] x;
    logic               y;
  } compound_type_t;
endpackage

module testbasic12_feeder
  import testbasic12_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  compound_type_t               c_in,
  input  logic                         c_in_sync,
  output logic                         c_in_notify,
  output compound_type_t               b_out,
  output logic                         b_out_notify,
  input  logic                         b_out_sync,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam compound_type_t RESET_VALUE = '{mode: MODE_READ, x: 32'sd0, y: 1'b0};

  compound_type_t mem [DEPTH];

  logic [PW-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0]  count_reg, count_next;
  compound_type_t b_out_reg, b_out_next;
  logic           b_out_notify_reg;
  logic           c_in_notify_reg;
  logic           enq, deq, pass_through, head_fwd;

  always_comb begin
`ifdef TESTBASIC12_FEEDER_BYPASS_EN
    pass_through = (count_reg == '0) && c_in_sync && b_out_sync;
`else
    pass_through = 1'b0;
`endif
    // A transaction that leaves in the same cycle it arrives is never stored.
    enq = c_in_sync && c_in_notify_reg && !pass_through;
    deq = b_out_notify_reg && b_out_sync;

    rd_ptr_next = deq ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
    wr_ptr_next = enq ? wr_ptr_reg + 1'b1 : wr_ptr_reg;

    count_next = count_reg;
    case ({enq, deq})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase

    // The slot being written this edge becomes the head: forward c_in past the array.
    head_fwd   = enq && (wr_ptr_reg == rd_ptr_next);
    b_out_next = b_out_reg;
    if (count_next != '0) begin
      b_out_next = head_fwd ? c_in : mem[rd_ptr_next];
    end
    if (pass_through) begin
      b_out_next = c_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg       <= '0;
      wr_ptr_reg       <= '0;
      count_reg        <= '0;
      b_out_reg        <= RESET_VALUE;
      b_out_notify_reg <= 1'b0;
      c_in_notify_reg  <= 1'b1;
    end else begin
      rd_ptr_reg       <= rd_ptr_next;
      wr_ptr_reg       <= wr_ptr_next;
      count_reg        <= count_next;
      b_out_reg        <= b_out_next;
      b_out_notify_reg <= (count_next != '0);
      c_in_notify_reg  <= (count_next < FULL);
    end
  end

  // Storage carries no reset; validity is tracked entirely by count_reg.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wr_ptr_reg] <= c_in;
    end
  end

`ifdef TESTBASIC12_FEEDER_BYPASS_EN
  assign b_out        = (count_reg == '0) ? c_in : b_out_reg;
  assign b_out_notify = (count_reg == '0) ? (c_in_sync && !rst) : b_out_notify_reg;
`else
  assign b_out        = b_out_reg;
  assign b_out_notify = b_out_notify_reg;
`endif
  assign c_in_notify  = c_in_notify_reg;
  assign level        = count_reg;

endmodule

// File: tb/tb_testbasic12_feeder.sv
// Scoreboard bench for testbasic12_feeder: driver pushes expected items, negedge monitor pops on handshake.

module tb_testbasic12_feeder;
  import testbasic12_types::*;

  localparam int DEPTH = 4;
`ifdef TESTBASIC12_FEEDER_BYPASS_EN
  localparam int STREAM_LEVEL = 0;
`else
  localparam int STREAM_LEVEL = 1;
`endif

  logic           clk = 1'b0;
  logic           rst;
  compound_type_t c_in;
  logic           c_in_sync;
  logic           c_in_notify;
  compound_type_t b_out;
  logic           b_out_notify;
  logic           b_out_sync;
  logic [2:0]     level;

  int checks   = 0;
  int failures = 0;
  compound_type_t exp_q[$];
  logic drv_done;

  testbasic12_feeder #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .c_in         (c_in),
    .c_in_sync    (c_in_sync),
    .c_in_notify  (c_in_notify),
    .b_out        (b_out),
    .b_out_notify (b_out_notify),
    .b_out_sync   (b_out_sync),
    .level        (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_item(input string name, input compound_type_t act, input compound_type_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got {mode=%0b x=%0d y=%0b} expected {mode=%0b x=%0d y=%0b} at %0t",
               name, act.mode, act.x, act.y, exp.mode, exp.x, exp.y, $time);
    end
  endtask

  function automatic compound_type_t mk(input mode_t m, input int x, input logic y);
    compound_type_t t;
    t.mode = m;
    t.x    = x;
    t.y    = y;
    return t;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge, c_in_sync left high.
  task automatic send(input compound_type_t t, output int stalls);
    logic done;
    c_in      = t;
    c_in_sync = 1'b1;
    exp_q.push_back(t);
    stalls = 0;
    done   = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (c_in_notify) begin
        done = 1'b1;
      end else begin
        stalls++;
        if (stalls > 200) begin
          checks++;
          failures++;
          $display("FAIL send_timeout: c_in_notify stuck at 0 for x=%0d", t.x);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_cycle();
    c_in_sync = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: the handshake seen at a negedge completes at the following posedge.
  initial begin : monitor
    compound_type_t prev_b;
    compound_type_t e;
    logic prev_hold;
    prev_hold = 1'b0;
    prev_b    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold && b_out_notify) check_item("hold_stable", b_out, prev_b);
        if (b_out_notify && b_out_sync) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output: got x=%0d with empty scoreboard", b_out.x);
          end else begin
            e = exp_q.pop_front();
            check_item("scoreboard", b_out, e);
            $display("pop mode=%0b x=%0d y=%0b level=%0d", b_out.mode, b_out.x, b_out.y, level);
          end
        end
        check("level_bound", 64'(level <= 3'(DEPTH)), 64'd1);
        prev_hold = b_out_notify && !b_out_sync;
        prev_b    = b_out;
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int stalls;
    int n;
    rst        = 1'b1;
    c_in       = '0;
    c_in_sync  = 1'b0;
    b_out_sync = 1'b0;
    drv_done   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_b_out_notify", 64'(b_out_notify), 64'd0);
    check("rst_c_in_notify", 64'(c_in_notify), 64'd1);
    check("rst_level", 64'(level), 64'd0);
    check_item("rst_b_out", b_out, mk(MODE_READ, 0, 1'b0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single transfer with a stalled consumer.
    send(mk(MODE_WRITE, 42, 1'b1), stalls);
    c_in_sync = 1'b0;
    check_item("single_b_out", b_out, mk(MODE_WRITE, 42, 1'b1));
    check("single_notify", 64'(b_out_notify), 64'd1);
    check("single_level", 64'(level), 64'd1);
    repeat (5) begin
      @(negedge clk);
      check_item("single_hold", b_out, mk(MODE_WRITE, 42, 1'b1));
    end
    @(posedge clk);
    #1;
    b_out_sync = 1'b1;
    @(posedge clk);
    #1;
    b_out_sync = 1'b0;
    check("single_popped_level", 64'(level), 64'd0);
    check("single_popped_notify", 64'(b_out_notify), 64'd0);

    // Fill to DEPTH, x=5 blocked until one pop.
    for (int i = 1; i <= 4; i++) begin
      send(mk(MODE_WRITE, i, 1'b0), stalls);
      check("fill_stall", 64'(stalls), 64'd0);
    end
    check("fill_full_notify", 64'(c_in_notify), 64'd0);
    check("fill_full_level", 64'(level), 64'd4);
    c_in      = mk(MODE_WRITE, 5, 1'b0);
    c_in_sync = 1'b1;
    exp_q.push_back(c_in);
    repeat (3) begin
      @(negedge clk);
      check("fill_x5_blocked", 64'(level), 64'd4);
    end
    @(posedge clk);
    #1;
    b_out_sync = 1'b1;
    @(posedge clk);
    #1;
    b_out_sync = 1'b0;
    check("fill_after_pop_notify", 64'(c_in_notify), 64'd1);
    check("fill_after_pop_level", 64'(level), 64'd3);
    @(posedge clk);
    #1;
    c_in_sync = 1'b0;
    check("fill_x5_taken_level", 64'(level), 64'd4);
    b_out_sync = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("fill_drain_bounded", 64'(n < 50), 64'd1);
    @(posedge clk);
    #1;
    b_out_sync = 1'b0;
    check("fill_drained_level", 64'(level), 64'd0);

    // Streaming: one per cycle both sides.
    b_out_sync = 1'b1;
    for (int i = 0; i < 100; i++) begin
      send(mk(MODE_WRITE, 1000 + i, 1'(i)), stalls);
      check("stream_stall", 64'(stalls), 64'd0);
      check("stream_level", 64'(level), 64'(STREAM_LEVEL));
    end
    c_in_sync = 1'b0;
    @(posedge clk);
    #1;
    b_out_sync = 1'b0;
    check("stream_end_level", 64'(level), 64'd0);

    // Random handshakes, 1000 transactions.
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          int s;
          while ($urandom_range(1, 0) == 1) idle_cycle();
          send(mk(mode_t'($urandom_range(1, 0)), int'($urandom), 1'($urandom_range(1, 0))), s);
        end
        c_in_sync = 1'b0;
        drv_done  = 1'b1;
      end
      begin
        int cyc;
        cyc = 0;
        @(posedge clk);
        #1;
        while (!(drv_done && exp_q.size() == 0) && cyc < 20000) begin
          b_out_sync = 1'($urandom_range(1, 0));
          @(posedge clk);
          #1;
          cyc++;
        end
        b_out_sync = 1'b0;
        check("random_drain_bounded", 64'(cyc < 20000), 64'd1);
      end
    join
    check("random_end_level", 64'(level), 64'd0);

    // Reset mid-cycle with 3 entries held.
    for (int i = 0; i < 3; i++) send(mk(MODE_WRITE, 77 + i, 1'b1), stalls);
    c_in_sync = 1'b0;
    check("pre_reset_level", 64'(level), 64'd3);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("midrst_b_out_notify", 64'(b_out_notify), 64'd0);
    check("midrst_c_in_notify", 64'(c_in_notify), 64'd1);
    check("midrst_level", 64'(level), 64'd0);
    check_item("midrst_b_out", b_out, mk(MODE_READ, 0, 1'b0));
    @(negedge clk);
    rst = 1'b0;
    b_out_sync = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("postrst_no_stale", 64'(b_out_notify), 64'd0);
      check("postrst_level", 64'(level), 64'd0);
    end
    @(posedge clk);
    #1;
    b_out_sync = 1'b0;

`ifdef TESTBASIC12_FEEDER_BYPASS_EN
    // Same-cycle pass-through when empty.
    b_out_sync = 1'b1;
    c_in       = mk(MODE_READ, -7, 1'b0);
    c_in_sync  = 1'b1;
    exp_q.push_back(c_in);
    #1;
    check("bypass_notify", 64'(b_out_notify), 64'd1);
    check_item("bypass_b_out", b_out, mk(MODE_READ, -7, 1'b0));
    @(posedge clk);
    #1;
    c_in_sync  = 1'b0;
    b_out_sync = 1'b0;
    check("bypass_level", 64'(level), 64'd0);
`endif

    // Single item after reset still flows.
    send(mk(MODE_READ, -3, 1'b1), stalls);
    c_in_sync  = 1'b0;
    b_out_sync = 1'b1;
    @(posedge clk);
    #1;
    b_out_sync = 1'b0;
    check("final_level", 64'(level), 64'd0);
    check("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
